// File: rtl/q78_row_max_sub.sv
`default_nettype none
// ============================================================================
// Module      : q78_row_max_sub
// Description : Buffers one row of signed Q7.8 samples, tracks the row max,
//               then replays the row as sat16(x - max) so every output is <= 0.
//               Optional macro Q78_ROWMAX_TUSER_EN adds m_axis_tuser (row max).
// Revision    : 1.0 - initial release
// ============================================================================
module q78_row_max_sub #(
    parameter int MAX_LEN = 64,
    parameter int AW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast,
`ifdef Q78_ROWMAX_TUSER_EN
    output logic [15:0] m_axis_tuser,
`endif
    output logic        row_overflow
);

    localparam logic [0:0]    c_ST_FILL   = 1'b0;
    localparam logic [0:0]    c_ST_DRAIN  = 1'b1;
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(MAX_LEN - 1);
    localparam logic [AW:0]   c_RD_ONE    = (AW+1)'(1);
    localparam logic [15:0]   c_MAX_INIT  = 16'h8000;

    logic [0:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_len;
    logic [15:0]   r_max;
    logic [15:0]   r_buf [0:MAX_LEN-1];

    logic          w_s_fire;
    logic          w_full;
    logic [15:0]   w_new_max;
    logic [15:0]   w_rd_data;
    logic [16:0]   w_diff;
    logic [15:0]   w_sat;
    logic          w_load;
    logic          w_end_hs;

    assign s_axis_tready = (r_state == c_ST_FILL);
    assign w_s_fire      = (r_state == c_ST_FILL) && s_axis_tvalid;
    assign w_full        = (r_wr_ptr == c_LAST_ADDR);
    assign w_new_max     = ((r_wr_ptr == '0) || ($signed(s_axis_tdata) > $signed(r_max)))
                           ? s_axis_tdata : r_max;

    // 17-bit difference spans [-65535, 0]; only the negative side can overflow.
    assign w_rd_data = r_buf[r_rd_ptr[AW-1:0]];
    assign w_diff    = {w_rd_data[15], w_rd_data} - {r_max[15], r_max};
    assign w_sat     = (w_diff[16] && !w_diff[15]) ? 16'h8000 : w_diff[15:0];

    assign w_load   = (r_state == c_ST_DRAIN) && (!m_axis_tvalid || m_axis_tready)
                      && (r_rd_ptr < r_len);
    assign w_end_hs = (r_state == c_ST_DRAIN) && m_axis_tvalid && m_axis_tready
                      && m_axis_tlast;

    // Row storage carries no reset: contents are dead once a row is dropped.
    always_ff @(posedge clk) begin
        if (w_s_fire) begin
            r_buf[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_FILL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_len         <= '0;
            r_max         <= c_MAX_INIT;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            row_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_s_fire) begin
                        r_max <= w_new_max;
                        if (s_axis_tlast || w_full) begin
                            r_state  <= c_ST_DRAIN;
                            r_len    <= (AW+1)'(r_wr_ptr) + c_RD_ONE;
                            r_wr_ptr <= '0;
                            if (!s_axis_tlast) begin
                                row_overflow <= 1'b1;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_end_hs) begin
                        m_axis_tvalid <= 1'b0;
                        r_rd_ptr      <= '0;
                        r_max         <= c_MAX_INIT;
                        r_state       <= c_ST_FILL;
                    end else if (w_load) begin
                        m_axis_tdata  <= w_sat;
                        m_axis_tlast  <= (r_rd_ptr == (r_len - c_RD_ONE));
                        m_axis_tvalid <= 1'b1;
                        r_rd_ptr      <= r_rd_ptr + c_RD_ONE;
                    end else if (m_axis_tvalid && m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef Q78_ROWMAX_TUSER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tuser <= '0;
        end else if (r_state == c_ST_DRAIN && !w_end_hs && w_load) begin
            m_axis_tuser <= r_max;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_q78_row_max_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_q78_row_max_sub
// Description : Scoreboard bench for q78_row_max_sub (default build and a
//               MAX_LEN=4 instance for truncation behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q78_row_max_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid [2];
    logic        s_ready [2];
    logic [15:0] s_data  [2];
    logic        s_last  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [15:0] m_data  [2];
    logic        m_last  [2];
    logic        ovf     [2];
`ifdef Q78_ROWMAX_TUSER_EN
    logic [15:0] m_user  [2];
`endif

    int          checks = 0;
    int          errors = 0;
    int          stall_err;
    int          tready_err;
    logic [16:0] exp_q [$];
    logic [16:0] got_q [$];

    always #5 clk = ~clk;

    q78_row_max_sub u_dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
        .s_axis_tdata(s_data[0]), .s_axis_tlast(s_last[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tlast(m_last[0]),
`ifdef Q78_ROWMAX_TUSER_EN
        .m_axis_tuser(m_user[0]),
`endif
        .row_overflow(ovf[0])
    );

    q78_row_max_sub #(.MAX_LEN(4), .AW(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
        .s_axis_tdata(s_data[1]), .s_axis_tlast(s_last[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tlast(m_last[1]),
`ifdef Q78_ROWMAX_TUSER_EN
        .m_axis_tuser(m_user[1]),
`endif
        .row_overflow(ovf[1])
    );

    // Drive one beat and hold it until accepted; returns on the negedge after acceptance.
    task automatic beat(input int u, input logic [15:0] d, input logic l);
        bit acc;
        acc = 1'b0;
        s_valid[u] = 1'b1; s_data[u] = d; s_last[u] = l;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = s_ready[u];
            @(negedge clk);
        end
        s_valid[u] = 1'b0; s_last[u] = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout unit %0d data %h not accepted", u, d);
        end
    endtask

    // Collect n output beats with a 16-cycle ready pattern; records stall and tready anomalies.
    task automatic capture(input int u, input int n, input logic [15:0] rpat, output int cyc);
        int          got;
        logic        stall;
        logic [16:0] held;
        got = 0; stall = 1'b0; held = '0; cyc = 0;
        stall_err = 0; tready_err = 0;
        for (int k = 0; k < 400 && got < n; k++) begin
            m_ready[u] = rpat[k % 16];
            if (s_ready[u]) tready_err++;
            if (stall && ({m_last[u], m_data[u]} !== held)) stall_err++;
            stall = m_valid[u] && !m_ready[u];
            held  = {m_last[u], m_data[u]};
            if (m_valid[u] && m_ready[u]) begin
                got_q.push_back({m_last[u], m_data[u]});
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        m_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (m_valid[u] !== 1'b0) begin errors++; $display("FAIL reset_tvalid unit %0d got %b want 0", u, m_valid[u]); end
            checks++;
            if (m_data[u] !== 16'h0000) begin errors++; $display("FAIL reset_tdata unit %0d got %h want 0000", u, m_data[u]); end
            checks++;
            if (m_last[u] !== 1'b0) begin errors++; $display("FAIL reset_tlast unit %0d got %b want 0", u, m_last[u]); end
            checks++;
            if (ovf[u] !== 1'b0) begin errors++; $display("FAIL reset_overflow unit %0d got %b want 0", u, ovf[u]); end
            checks++;
            if (s_ready[u] !== 1'b1) begin errors++; $display("FAIL reset_tready unit %0d got %b want 1", u, s_ready[u]); end
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b0, 16'hFF00});
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b1, 16'hFD00});
        beat(0, 16'h0100, 1'b0);
        beat(0, 16'h0200, 1'b0);
        beat(0, 16'hFF00, 1'b1);
        checks++;
        if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_latency_early got tvalid %b want 0", m_valid[0]); end
        checks++;
        if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL basic_drain_tready got %b want 0", s_ready[0]); end
        @(negedge clk);
        checks++;
        if (m_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_latency_first got tvalid %b want 1", m_valid[0]); end
        capture(0, 3, 16'hFFFF, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL basic_consecutive got %0d cycles want 3", cyc); end
        checks++;
        if (s_ready[0] !== 1'b1 || m_valid[0] !== 1'b0) begin
            errors++; $display("FAIL basic_return_fill got tready %b tvalid %b want 1 0", s_ready[0], m_valid[0]);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL basic_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_saturate();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b0, 16'h8000});
        exp_q.push_back({1'b1, 16'h0000});
        beat(0, 16'h8000, 1'b0);
        beat(0, 16'h7FFF, 1'b1);
        capture(0, 2, 16'hFFFF, cyc);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL sat_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_single_then_max_reset();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b1, 16'h0000});
        beat(0, 16'h1234, 1'b1);
        capture(0, 1, 16'hFFFF, cyc);
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b1, 16'hFF00});
        beat(0, 16'hFF00, 1'b0);
        beat(0, 16'hFE00, 1'b1);
        capture(0, 2, 16'hFFFF, cyc);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL single_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b0, 16'hFF00});
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b1, 16'hFD00});
        beat(0, 16'h0100, 1'b0);
        beat(0, 16'h0200, 1'b0);
        beat(0, 16'hFF00, 1'b1);
        capture(0, 3, 16'h9999, cyc);
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        checks++;
        if (tready_err !== 0) begin errors++; $display("FAIL bp_tready_low got %0d high cycles want 0", tready_err); end
        checks++;
        if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_return_fill got %b want 1", s_ready[0]); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL bp_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_full_row_tlast();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b0, 16'hFFFD});
        exp_q.push_back({1'b0, 16'hFFFE});
        exp_q.push_back({1'b0, 16'hFFFF});
        exp_q.push_back({1'b1, 16'h0000});
        for (int i = 1; i <= 4; i++) beat(1, 16'(i), (i == 4));
        checks++;
        if (ovf[1] !== 1'b0) begin errors++; $display("FAIL full_tlast_overflow got %b want 0", ovf[1]); end
        capture(1, 4, 16'hFFFF, cyc);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL full_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        int cyc;
        logic [16:0] e, g;
        exp_q.push_back({1'b0, 16'hFFFD});
        exp_q.push_back({1'b0, 16'hFFFE});
        exp_q.push_back({1'b0, 16'hFFFF});
        exp_q.push_back({1'b1, 16'h0000});
        for (int i = 1; i <= 4; i++) beat(1, 16'(i), 1'b0);
        checks++;
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf[1]); end
        capture(1, 4, 16'hFFFF, cyc);
        // Beat 5 opens a fresh row, closed by a tlast beat of 2.
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b1, 16'hFFFD});
        beat(1, 16'd5, 1'b0);
        beat(1, 16'd2, 1'b1);
        capture(1, 2, 16'hFFFF, cyc);
        checks++;
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf[1]); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL ovf_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        logic [16:0] e, g;
        beat(0, 16'h0100, 1'b0);
        beat(0, 16'h0200, 1'b0);
        beat(0, 16'hFF00, 1'b1);
        @(negedge clk);
        m_ready[0] = 1'b1;
        @(negedge clk);
        m_ready[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_valid[0]); end
        checks++;
        if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_tready got %b want 1", s_ready[0]); end
        checks++;
        if (ovf[1] !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b want 0", ovf[1]); end
        exp_q.push_back({1'b1, 16'h0000});
        beat(0, 16'h0300, 1'b1);
        capture(0, 1, 16'hFFFF, cyc);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL rstmid_beat got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = 1'b0; s_data[u] = '0; s_last[u] = 1'b0; m_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_single_then_max_reset();
        test_backpressure();
        test_full_row_tlast();
        test_overflow();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
